// File: rtl/lut_neuron_array.sv
// lut_neuron_array: runtime-loadable lookup-table neurons sharing a two-stage valid/ready pipeline.
// Tables clear themselves after reset (INIT) before lookups and config writes are accepted.
module lut_neuron_array #(
   parameter int NUM_NEURONS = 4,
   parameter int IN_BITS     = 8,
   parameter int OUT_BITS    = 2,
   parameter int NID_BITS    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
   input  logic                            cfg_we,
   input  logic [NID_BITS-1:0]             cfg_neuron,
   input  logic [IN_BITS-1:0]              cfg_addr,
   input  logic [OUT_BITS-1:0]             cfg_data,
   output logic                            cfg_ready,
   output logic                            busy
);
   typedef enum logic {INIT, RUN} state_t;
   state_t                          state;
   logic [IN_BITS-1:0]              init_cnt;
   logic                            s1_valid;
   logic [NUM_NEURONS*IN_BITS-1:0]  s1_data;
   logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
   logic                            adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = (state == RUN) && adv;
   // Selects that match no lane (cfg_neuron >= NUM_NEURONS) fall through and are dropped.
   for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
      logic [OUT_BITS-1:0] mem [2**IN_BITS];
      always_ff @(posedge clk)
         if (state == INIT) mem[init_cnt] <= '0;
         else if (cfg_we && cfg_neuron == NID_BITS'(n)) mem[cfg_addr] <= cfg_data;
      assign lookup[n*OUT_BITS +: OUT_BITS] = mem[s1_data[n*IN_BITS +: IN_BITS]];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= INIT;
         init_cnt  <= '0;
         busy      <= 1'b1;
         cfg_ready <= 1'b0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
               state     <= RUN;
               busy      <= 1'b0;
               cfg_ready <= 1'b1;
            end
         end
         if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= lookup;
            s1_valid <= in_valid && in_ready;
            if (in_valid && in_ready) s1_data <= in_data;
         end
      end
endmodule

// File: tb/tb_lut_neuron_array.sv
// tb_lut_neuron_array: directed checks of init, lookup, streaming, collisions and reset.
module tb_lut_neuron_array;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
   logic [31:0] in_data = '0;
   logic [1:0] cfg_neuron = '0, cfg_data = '0;
   logic [7:0] cfg_addr = '0;
   logic in_ready, out_valid, cfg_ready, busy;
   logic [7:0] out_data;
   logic in_valid3 = 1'b0, cfg_we3 = 1'b0;
   logic [23:0] in_data3 = '0;
   logic [1:0] cfg_neuron3 = '0, cfg_data3 = '0;
   logic [7:0] cfg_addr3 = '0;
   logic in_ready3, out_valid3, cfg_ready3, busy3;
   logic [5:0] out_data3;
   int total = 0, passed = 0;
   always #5 clk = ~clk;
   lut_neuron_array dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
      .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .busy(busy));
   // Three lanes with a 2-bit select lets the out-of-range neuron drop be exercised.
   lut_neuron_array #(.NUM_NEURONS(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
      .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .cfg_we(cfg_we3),
      .cfg_neuron(cfg_neuron3), .cfg_addr(cfg_addr3), .cfg_data(cfg_data3),
      .cfg_ready(cfg_ready3), .busy(busy3));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
   endtask
   task automatic cfg_wr(input logic [1:0] n, input logic [7:0] a, input logic [1:0] d);
      cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask
   task automatic lookup(input string tag, input logic [31:0] a, input logic [7:0] e);
      in_data = a; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1);
      chk(tag, out_data, e);
   endtask
   task automatic wait_init(input string tag, input logic poke);
      int cnt = 0;
      logic bad = 1'b0;
      cfg_we = poke; cfg_neuron = 2'd0; cfg_addr = 8'h55; cfg_data = 2'b11;
      while (busy && cnt < 1000) begin
         if (in_ready || cfg_ready) bad = 1'b1;
         @(negedge clk);
         cnt++;
      end
      cfg_we = 1'b0;
      chk({tag, "_len"}, cnt, 256);
      chk({tag, "_rdy_low"}, bad, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 1);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask
   function automatic logic [31:0] beat(input int i);
      logic [7:0] b = 8'(i);
      return {8'h00, b, b, 8'h00};
   endfunction
   function automatic logic [7:0] beat_exp(input int i);
      logic [3:0] b = 4'(i);
      return {2'b00, b[1:0], b[3:2], 2'b10};
   endfunction
   initial begin
      int tx, rx;
      logic acc, take;
      logic [7:0] held;
      held = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      rst = 1'b0;
      wait_init("init", 1'b1);
      lookup("first_lookup", 32'h00_40_80_C0, 8'h00);
      lookup("init_write_ignored", 32'h00_00_00_55, 8'h00);
      cfg_wr(2'd0, 8'h00, 2'b10);
      cfg_wr(2'd0, 8'h40, 2'b01);
      cfg_wr(2'd3, 8'hC0, 2'b11);
      in_data = 32'hC0_00_00_00; in_valid = 1'b1;
      @(negedge clk);
      in_data = 32'h00_00_00_40;
      @(negedge clk);
      in_valid = 1'b0;
      chk("pair0_valid", out_valid, 1);
      chk("pair0_data", out_data, 8'hC2);
      @(negedge clk);
      chk("pair1_valid", out_valid, 1);
      chk("pair1_data", out_data, 8'h01);
      @(negedge clk);
      chk("pair_drained", out_valid, 0);
      for (int i = 0; i < 16; i++) begin
         cfg_wr(2'd2, 8'(i), 2'(i));
         cfg_wr(2'd1, 8'(i), 2'(i >> 2));
      end
      tx = 0; rx = 0;
      for (int c = 0; c < 60 && rx < 16; c++) begin
         out_ready = !(c >= 5 && c <= 7);
         in_valid = tx < 16;
         in_data = beat(tx);
         #1;
         acc = in_valid && in_ready;
         take = out_valid && out_ready;
         if (take) begin
            chk("stream_data", out_data, beat_exp(rx));
            rx++;
         end
         if (c == 5) held = out_data;
         if (c == 7) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_hold", out_data, held);
         end
         @(negedge clk);
         if (acc) tx++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_rx", rx, 16);
      chk("stream_tx", tx, 16);
      @(negedge clk);
      chk("stream_empty", out_valid, 0);
      in_data = 32'h00_00_10_00; in_valid = 1'b1;
      @(negedge clk);
      cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 8'h10; cfg_data = 2'b11;
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      chk("collide_old_valid", out_valid, 1);
      chk("collide_old", out_data, 8'h02);
      @(negedge clk);
      chk("collide_new_valid", out_valid, 1);
      chk("collide_new", out_data, 8'h0E);
      cfg_we3 = 1'b1; cfg_neuron3 = 2'd3; cfg_addr3 = 8'h22; cfg_data3 = 2'b11;
      @(negedge clk);
      cfg_neuron3 = 2'd2; cfg_data3 = 2'b01;
      @(negedge clk);
      cfg_we3 = 1'b0; in_data3 = 24'h22_22_22; in_valid3 = 1'b1;
      @(negedge clk);
      in_valid3 = 1'b0;
      @(negedge clk);
      chk("oor_drop_valid", out_valid3, 1);
      chk("oor_drop_data", out_data3, 6'h10);
      out_ready = 1'b0; in_data = 32'h00_00_00_40; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_data", out_data, 8'h01);
      rst = 1'b1;
      #1;
      chk("async_out_valid", out_valid, 0);
      chk("async_busy", busy, 1);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      wait_init("reinit", 1'b0);
      lookup("cleared_a", 32'h00_00_00_40, 8'h00);
      lookup("cleared_b", 32'hC0_00_10_00, 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
